// File: rtl/bdpsk_phase_gen_if.sv
// Bit-stream handshake between the data source and bdpsk_phase_gen.
//   bit_valid : source has a data bit on bit_in
//   bit_in    : raw data bit
//   bit_ready : phase generator can take a bit this cycle
// master = bit source, slave = phase generator.
interface bdpsk_phase_gen_if;
    logic bit_valid;
    logic bit_in;
    logic bit_ready;

    modport master (output bit_valid, output bit_in, input bit_ready);
    modport slave  (input bit_valid, input bit_in, output bit_ready);
endinterface

// File: rtl/bdpsk_phase_gen.sv
// BDPSK sine-LUT address generator.
// Takes serial bits over a valid/ready handshake, differentially encodes
// them and drives a 7-bit LUT address = phase + 64*diff_bit. Each symbol
// spans a whole number of carrier periods, so the phase accumulator is back
// at 0 on every symbol boundary and the carrier phase stays continuous.
//   clk, reset : clock, synchronous active-high reset
//   bit_if     : slave side of the bit handshake (bit_valid/bit_in/bit_ready)
//   address    : registered LUT address
//   sym_start  : high for the first sample of each symbol
//   diff_bit   : current differentially encoded bit
//   busy       : a symbol is being emitted
module bdpsk_phase_gen #(
    parameter int CYCLES_PER_SYMBOL = 4,
    parameter int PHASE_STEP        = 4
) (
    input  logic               clk,
    input  logic               reset,
    bdpsk_phase_gen_if.slave   bit_if,
    output logic [6:0]         address,
    output logic               sym_start,
    output logic               diff_bit,
    output logic               busy
);
    localparam int SYM_LEN = CYCLES_PER_SYMBOL * 128 / PHASE_STEP;
    localparam int CNT_W   = $clog2(SYM_LEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(SYM_LEN - 1);
    localparam logic [6:0]       STEP7 = 7'(PHASE_STEP);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [6:0]       phase, phase_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             hold_full, hold_full_n;
    logic             hold_bit, hold_bit_n;
    logic [6:0]       address_n;
    logic             sym_start_n, diff_n, busy_n;
    logic             xfer, start, start_bit;

    assign bit_if.bit_ready = !hold_full;
    assign xfer = bit_if.bit_valid && !hold_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
            hold_bit  <= 1'b0;
            address   <= '0;
            sym_start <= 1'b0;
            diff_bit  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            cnt       <= cnt_n;
            hold_full <= hold_full_n;
            hold_bit  <= hold_bit_n;
            address   <= address_n;
            sym_start <= sym_start_n;
            diff_bit  <= diff_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        phase_n     = phase;
        cnt_n       = cnt;
        hold_full_n = hold_full;
        hold_bit_n  = hold_bit;
        address_n   = address;
        sym_start_n = 1'b0;
        diff_n      = diff_bit;
        busy_n      = busy;
        start       = 1'b0;
        start_bit   = bit_if.bit_in;

        case (state)
            IDLE: begin
                address_n = '0;
                busy_n    = 1'b0;
                // Zero-latency start: the bit goes straight in, never via the holding register.
                if (xfer) start = 1'b1;
            end
            RUN: begin
                if (cnt != LAST) begin
                    cnt_n     = cnt + CNT_W'(1);
                    phase_n   = phase + STEP7;
                    address_n = phase + STEP7 + {diff_bit, 6'b0};
                    if (xfer) begin
                        hold_full_n = 1'b1;
                        hold_bit_n  = bit_if.bit_in;
                    end
                end else if (hold_full) begin
                    start       = 1'b1;
                    start_bit   = hold_bit;
                    hold_full_n = 1'b0;
                end else if (xfer) begin
                    start = 1'b1;
                end else begin
                    state_n   = IDLE;
                    address_n = '0;
                    busy_n    = 1'b0;
                    phase_n   = '0;
                    cnt_n     = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Symbol start: phase restarts at 0, so the first sample is 0 or 64.
        if (start) begin
            diff_n      = diff_bit ^ start_bit;
            state_n     = RUN;
            phase_n     = '0;
            cnt_n       = '0;
            address_n   = {diff_n, 6'b0};
            sym_start_n = 1'b1;
            busy_n      = 1'b1;
        end
    end
endmodule
